// File: rtl/nonce_drain.sv
// nonce_drain: deserializes the miner nonce bit stream into words and queues them for host readout
module nonce_drain #(
    parameter int NONCEBITS = 32,
    parameter int DEPTH     = 8,
    parameter int FILTER    = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         resultValid,
    input  logic                         success,
    input  logic                         nonceBit,
    input  logic                         overflowIn,
    input  logic                         flush,
    output logic                         outValid,
    input  logic                         outReady,
    output logic [NONCEBITS-1:0]         outNonce,
    output logic                         outSuccess,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow,
    input  logic                         clearOverflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam int CW = $clog2(NONCEBITS);
    logic [NONCEBITS-1:0] shift, word;
    logic [CW-1:0]        bit_cnt;
    logic                 acc, flag, done, push_req, push, pop, full, drop;
    logic [NONCEBITS:0]   mem [DEPTH];
    logic [AW-1:0]        rd_ptr, wr_ptr;
    always_comb begin
        word       = {shift[NONCEBITS-2:0], nonceBit};
        flag       = acc | success;
        done       = resultValid && !flush && bit_cnt == CW'(NONCEBITS-1);
        push_req   = done && (FILTER == 0 || flag);
        outValid   = level != '0;
        pop        = outValid && outReady;
        full       = level == LW'(DEPTH);
        push       = push_req && (!full || pop);
        drop       = push_req && full && !pop;
        outNonce   = outValid ? mem[rd_ptr][NONCEBITS-1:0] : '0;
        outSuccess = outValid ? mem[rd_ptr][NONCEBITS] : 1'b0;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift    <= '0;
            bit_cnt  <= '0;
            acc      <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (flush) begin
                shift   <= '0;
                bit_cnt <= '0;
                acc     <= 1'b0;
            end else if (resultValid) begin
                shift   <= word;
                bit_cnt <= done ? '0 : bit_cnt + CW'(1);
                acc     <= done ? 1'b0 : flag;
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            level    <= push && !pop ? level + LW'(1) : pop && !push ? level - LW'(1) : level;
            overflow <= overflowIn || drop ? 1'b1 : clearOverflow ? 1'b0 : overflow;
        end
    end
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {flag, word};
endmodule

// File: tb/tb_nonce_drain.sv
// tb_nonce_drain: scoreboard bench driving a FILTER=1 and a FILTER=0 instance from one bit stream
module tb_nonce_drain;
    logic clk = 0, rst = 0;
    logic resultValid = 0, success = 0, nonceBit = 0, overflowIn = 0, flush = 0, clearOverflow = 0;
    logic outReady1 = 0, outReady0 = 1;
    logic outValid1, outSuccess1, overflow1, outValid0, outSuccess0, overflow0;
    logic [31:0] outNonce1, outNonce0;
    logic [3:0] level1, level0;
    logic [32:0] q1[$], q0[$];
    int nchk = 0, nfail = 0;

    always #5 clk = ~clk;

    nonce_drain #(.NONCEBITS(32), .DEPTH(8), .FILTER(1)) dut1 (
        .clk(clk), .rst(rst), .resultValid(resultValid), .success(success), .nonceBit(nonceBit),
        .overflowIn(overflowIn), .flush(flush), .outValid(outValid1), .outReady(outReady1),
        .outNonce(outNonce1), .outSuccess(outSuccess1), .level(level1), .overflow(overflow1),
        .clearOverflow(clearOverflow));

    nonce_drain #(.NONCEBITS(32), .DEPTH(8), .FILTER(0)) dut0 (
        .clk(clk), .rst(rst), .resultValid(resultValid), .success(success), .nonceBit(nonceBit),
        .overflowIn(overflowIn), .flush(flush), .outValid(outValid0), .outReady(outReady0),
        .outNonce(outNonce0), .outSuccess(outSuccess0), .level(level0), .overflow(overflow0),
        .clearOverflow(clearOverflow));

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        nchk++;
        if (a !== e) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    always @(negedge clk) begin
        logic [32:0] e;
        if (rst && outValid1 && outReady1) begin
            if (q1.size() == 0) chk("d1_unexpected_pop", 32'd1, 32'd0);
            else begin
                e = q1.pop_front();
                chk("d1_nonce", outNonce1, e[31:0]);
                chk("d1_success", {31'd0, outSuccess1}, {31'd0, e[32]});
            end
        end
    end

    always @(negedge clk) begin
        logic [32:0] e;
        if (rst && outValid0 && outReady0) begin
            if (q0.size() == 0) chk("d0_unexpected_pop", 32'd1, 32'd0);
            else begin
                e = q0.pop_front();
                chk("d0_nonce", outNonce0, e[31:0]);
                chk("d0_success", {31'd0, outSuccess0}, {31'd0, e[32]});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, input logic [31:0] smask, input int gap,
                             input bit keep, input bit rdy_last);
        if (keep && |smask) q1.push_back({1'b1, w});
        q0.push_back({|smask, w});
        for (int i = 0; i < 32; i++) begin
            resultValid = 1;
            nonceBit = w[31-i];
            success = smask[i];
            if (rdy_last && i == 31) outReady1 = 1;
            cyc();
            resultValid = 0;
            success = 0;
            nonceBit = 0;
            if (rdy_last && i == 31) outReady1 = 0;
            repeat (gap) cyc();
        end
    endtask

    task automatic drain1();
        outReady1 = 1;
        for (int i = 0; i < 100 && q1.size() != 0; i++) cyc();
        outReady1 = 0;
        chk("drain_left", q1.size(), 0);
        chk("drain_level", {28'd0, level1}, 0);
    endtask

    initial begin
        #3;
        chk("rst_valid", {31'd0, outValid1}, 0);
        chk("rst_level", {28'd0, level1}, 0);
        chk("rst_ovf", {31'd0, overflow1}, 0);
        chk("rst_nonce", outNonce1, 0);
        chk("rst_success", {31'd0, outSuccess1}, 0);
        #9 rst = 1;
        cyc();

        send_word(32'hDEADBEEF, 32'h10, 0, 1, 0);
        @(negedge clk);
        chk("t1_valid", {31'd0, outValid1}, 1);
        chk("t1_level", {28'd0, level1}, 1);
        cyc();
        drain1();

        send_word(32'h12345678, 32'h0, 0, 1, 0);
        @(negedge clk);
        chk("t2_level", {28'd0, level1}, 0);
        chk("t2_valid", {31'd0, outValid1}, 0);
        cyc();

        send_word(32'h00000001, 32'h80000000, 3, 1, 0);
        for (int i = 0; i < 10; i++) begin
            resultValid = 1; nonceBit = 1; success = 1;
            cyc();
        end
        flush = 1;
        cyc();
        flush = 0; resultValid = 0; success = 0; nonceBit = 0;
        send_word(32'h80000000, 32'h0, 0, 1, 0);
        repeat (3) cyc();
        drain1();

        for (int k = 1; k <= 8; k++) send_word(k, 32'h1, 0, 1, 0);
        @(negedge clk);
        chk("t4_level8", {28'd0, level1}, 8);
        chk("t4_ovf_before", {31'd0, overflow1}, 0);
        chk("t4_head_stable", outNonce1, 1);
        cyc();
        send_word(9, 32'h1, 0, 0, 0);
        @(negedge clk);
        chk("t4_ovf_after", {31'd0, overflow1}, 1);
        chk("t4_level_full", {28'd0, level1}, 8);
        cyc();
        drain1();
        clearOverflow = 1;
        cyc();
        clearOverflow = 0;
        @(negedge clk);
        chk("t4_ovf_clear", {31'd0, overflow1}, 0);
        cyc();

        for (int k = 1; k <= 8; k++) send_word(k, 32'h2, 0, 1, 0);
        send_word(9, 32'h2, 0, 1, 1);
        @(negedge clk);
        chk("t5_level", {28'd0, level1}, 8);
        chk("t5_ovf", {31'd0, overflow1}, 0);
        cyc();
        drain1();

        overflowIn = 1; clearOverflow = 1;
        cyc();
        overflowIn = 0; clearOverflow = 0;
        @(negedge clk);
        chk("t6_set_wins", {31'd0, overflow1}, 1);
        cyc();
        for (int k = 0; k < 3; k++) send_word(32'hA0 + k, 32'h4, 0, 1, 0);
        repeat (3) cyc();
        for (int i = 0; i < 7; i++) begin
            resultValid = 1; nonceBit = i[0]; success = 1;
            cyc();
        end
        resultValid = 0; success = 0;
        #2 rst = 0;
        #1;
        chk("t6_rst_valid", {31'd0, outValid1}, 0);
        chk("t6_rst_level", {28'd0, level1}, 0);
        chk("t6_rst_ovf", {31'd0, overflow1}, 0);
        q1.delete();
        #3 rst = 1;
        cyc();
        send_word(32'hCAFEF00D, 32'h1, 0, 1, 0);
        @(negedge clk);
        chk("t6_post_level", {28'd0, level1}, 1);
        cyc();
        drain1();
        repeat (3) cyc();
        chk("d0_left", q0.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/nonce_drain.md
Name: nonce_drain

Overview:
- Consumer end of the miner's nonce-buffer write path.
- Collects the 1-bit-per-cycle nonce stream and the success/overflow flags the miner emits, and assembles them into NONCEBITS-wide nonce words.
- Queues completed words in a DEPTH-entry FIFO, which the host-side reader drains with a valid/ready handshake.
- Sits between the miner top level and the host readout logic.

Parameters:
- NONCEBITS, 32: bits per assembled nonce word; must be at least 2.
- DEPTH, 8: FIFO entries; power of two, at least 2.
- FILTER, 1: 1 = enqueue only words whose success flag is set; 0 = enqueue every completed word.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous active-low reset.
- resultValid  in  1  nonceBit/success are valid this cycle.
- success  in  1  miner success flag, sampled only when resultValid=1.
- nonceBit  in  1  serial nonce bit, sampled only when resultValid=1.
- overflowIn  in  1  writer-side overflow indication.
- flush  in  1  discard the partially assembled word; FIFO is untouched.
- outValid  out  1  head FIFO entry is available.
- outReady  in  1  host accepts the head entry.
- outNonce  out  NONCEBITS  head entry nonce.
- outSuccess  out  1  head entry success flag.
- level  out  $clog2(DEPTH+1)  number of occupied entries.
- overflow  out  1  sticky overflow flag.
- clearOverflow  in  1  clears the overflow flag.

Behaviour:
- Reset (rst=0, asynchronous): shift register, bit counter, success accumulator, FIFO pointers and overflow all clear. outValid=0, outNonce=0, outSuccess=0, level=0.
- Deserializer, on each cycle with resultValid=1:
  - shift = {shift[NONCEBITS-2:0], nonceBit}, so the first bit received ends up as the word MSB.
  - acc |= success.
  - bitCnt increments modulo NONCEBITS.
- Word completion: the cycle with resultValid=1 and bitCnt==NONCEBITS-1.
  - Completed word = {shift[NONCEBITS-2:0], nonceBit}.
  - Completed flag = acc | success.
  - bitCnt and acc return to 0 on the same edge.
- resultValid=0: all deserializer state holds. There is no timeout.
- flush=1: bitCnt, acc and shift clear on that edge. flush has priority over a same-cycle resultValid; that bit is discarded. FIFO contents are unaffected.
- Push request: word completion && (FILTER==0 || completed flag==1).
- Pop: outValid && outReady.
- outValid: equals level!=0.
  - outNonce/outSuccess present the head entry combinationally from the registered FIFO.
  - outNonce/outSuccess are don't-care while outValid=0.
- Latency: a word pushed into an empty FIFO at edge N gives outValid=1 in the cycle after edge N.
  - There is no same-cycle bypass, so an empty FIFO never pops on the push cycle.
- Full (level==DEPTH), push with no pop: the word is dropped and overflow is set.
- Full, push and pop in the same cycle: both take effect; level stays DEPTH and no overflow.
- Push and pop in the same cycle, not full: level unchanged.
- Empty: outReady is ignored and level never underflows.
- Pointers: log2(DEPTH)-bit read/write pointers wrap naturally. level is a separate up/down counter, range 0..DEPTH.
- overflow set sources: overflowIn=1 (any cycle), or a dropped push.
- overflow clear: clearOverflow=1. Set has priority over a same-cycle clear.
- Outputs remain stable while outValid=1 && outReady=0.

Test Plan:
- Reset, then FILTER=1, 32 valid cycles of bits for nonce 0xDEADBEEF MSB-first, success=1 on cycle 5 only -> outValid rises the cycle after the last bit; outNonce=0xDEADBEEF, outSuccess=1, level=1.
- FILTER=1, 32 valid cycles, success always 0 -> no push; level stays 0. FILTER=0, same stimulus -> entry pushed with outSuccess=0.
- Stream 0x00000001 interleaved with resultValid=0 gaps of 3 cycles; assert flush after bit 10 of a second word, then send a full 0x80000000 -> entries read back exactly 0x00000001 then 0x80000000.
- outReady=0, push 9 words into DEPTH=8 -> level=8, overflow=1 after the 9th; drain yields words 1..8 in order. clearOverflow then returns overflow to 0.
- Full FIFO, 9th word completes in the same cycle as outReady=1 -> overflow stays 0, level stays 8, and the 9th word is read last.
- overflowIn=1 and clearOverflow=1 in the same cycle -> overflow=1. Assert rst=0 mid-word with 3 entries queued -> outValid=0 and level=0 immediately, without waiting for a clock edge.
